// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
//   Bundles the two write-back request channels and the register-file write
//   port that the arbiter drives.
//   Handshake: a request is presented with reqX_valid_i high and addr/data
//   held stable; it transfers in the cycle where reqX_valid_i and
//   reqX_ready_o are both high. ready is derived from the valid inputs and
//   arbiter state only, never from the requester's own ready, and at most
//   one ready is high in any cycle.
//   Modports:
//     slave  - arbiter side (takes requests, drives ready + write port)
//     master - requester/register-file side
interface wb_port_arbiter_if #(
    parameter int N_bits = 32
);
    logic              req0_valid_i;
    logic [4:0]        req0_addr_i;
    logic [N_bits-1:0] req0_data_i;
    logic              req0_ready_o;

    logic              req1_valid_i;
    logic [4:0]        req1_addr_i;
    logic [N_bits-1:0] req1_data_i;
    logic              req1_ready_o;

    logic              Reg_Write_o;
    logic [4:0]        Write_Register_o;
    logic [N_bits-1:0] Write_Data_o;

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        output req0_ready_o,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        output req1_ready_o,
        output Reg_Write_o, Write_Register_o, Write_Data_o
    );

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        input  req0_ready_o,
        output req1_valid_i, req1_addr_i, req1_data_i,
        input  req1_ready_o,
        input  Reg_Write_o, Write_Register_o, Write_Data_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the ALU write-back
//   (req0) and the load write-back (req1). Round-robin arbitration; the
//   winning request is registered onto the write port one cycle later.
//   Writes to register 0 are accepted but never enabled. A saturating
//   counter records cycles in which both requests were valid.
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     hold_i       1 = no grants this cycle
//     bus          request channels + write port (slave modport)
//     contention_o saturating count of both-valid cycles
//     pri_state_o  debug view of the priority state (0 = PRI0, 1 = PRI1)
module wb_port_arbiter #(
    parameter int N_bits = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    wb_port_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]  contention_o,
    output logic              pri_state_o
);

    typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

    pri_t state, state_next;
    logic grant0, grant1;
    logic both_valid;

    assign both_valid = bus.req0_valid_i & bus.req1_valid_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= PRI0;
        else       state <= state_next;
    end

    // Grant is combinational from valids and state only; reset gates ready
    // low so nothing is accepted while reset is asserted.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        if (!reset && !hold_i) begin
            if (bus.req0_valid_i && (!bus.req1_valid_i || state == PRI0))
                grant0 = 1'b1;
            else if (bus.req1_valid_i)
                grant1 = 1'b1;
        end
        if (grant0)      state_next = PRI1;
        else if (grant1) state_next = PRI0;
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign pri_state_o      = state;

    // Write port: addr/data follow the accepted request and hold otherwise;
    // the enable is suppressed for register 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.Reg_Write_o      <= 1'b0;
            bus.Write_Register_o <= '0;
            bus.Write_Data_o     <= '0;
        end else begin
            bus.Reg_Write_o <= 1'b0;
            if (grant0) begin
                bus.Reg_Write_o      <= (bus.req0_addr_i != 5'd0);
                bus.Write_Register_o <= bus.req0_addr_i;
                bus.Write_Data_o     <= bus.req0_data_i;
            end else if (grant1) begin
                bus.Reg_Write_o      <= (bus.req1_addr_i != 5'd0);
                bus.Write_Register_o <= bus.req1_addr_i;
                bus.Write_Data_o     <= bus.req1_data_i;
            end
        end
    end

    // Contention counts regardless of hold_i; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            contention_o <= '0;
        else if (both_valid && (contention_o != {CNT_W{1'b1}}))
            contention_o <= contention_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int N_bits = 32;
    localparam int CNT_W  = 16;

    logic             clk;
    logic             reset;
    logic             hold_i;
    logic [CNT_W-1:0] contention_o;
    logic             pri_state_o;

    int checks;
    int errors;

    wb_port_arbiter_if #(.N_bits(N_bits)) bus ();

    wb_port_arbiter #(.N_bits(N_bits), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hold_i       (hold_i),
        .bus          (bus.slave),
        .contention_o (contention_o),
        .pri_state_o  (pri_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;   // expected ready this cycle
        logic        r1;
        logic        we;   // expected registered outputs after the edge
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic hold, logic v0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic [4:0] a1, logic [31:0] d1,
                                logic r0, logic r1, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic [15:0] cnt);
        vec_t v;
        v.hold = hold; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic hold, input logic v0, input logic [4:0] a0,
                         input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                         input logic [31:0] d1);
        hold_i           = hold;
        bus.req0_valid_i = v0;
        bus.req0_addr_i  = a0;
        bus.req0_data_i  = d0;
        bus.req1_valid_i = v1;
        bus.req1_addr_i  = a1;
        bus.req1_data_i  = d1;
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [15:0] cnt);
        check({tag, " Reg_Write"},      64'(bus.Reg_Write_o),      64'(we));
        check({tag, " Write_Register"}, 64'(bus.Write_Register_o), 64'(wa));
        check({tag, " Write_Data"},     64'(bus.Write_Data_o),     64'(wd));
        check({tag, " contention"},     64'(contention_o),         64'(cnt));
    endtask

    // One vector = one clock cycle: drive at negedge, check ready before the
    // rising edge, check registered outputs just after it.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v.hold, v.v0, v.a0, v.d0, v.v1, v.a1, v.d1);
        #1;
        check({tag, " req0_ready"}, 64'(bus.req0_ready_o), 64'(v.r0));
        check({tag, " req1_ready"}, 64'(bus.req1_ready_o), 64'(v.r1));
        @(posedge clk);
        #1;
        check_outputs(tag, v.we, v.wa, v.wd, v.cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        //          hold v0 a0    d0             v1 a1    d1       r0 r1 we wa    wd             cnt
        vecs[0]  = mk(0, 1, 5'd5, 32'hDEADBEEF,  0, 5'd0, 32'h0,   1, 0, 1, 5'd5, 32'hDEADBEEF, 16'd0);
        vecs[1]  = mk(0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,   0, 0, 0, 5'd5, 32'hDEADBEEF, 16'd0);
        vecs[2]  = mk(0, 0, 5'd0, 32'h0,         1, 5'd0, 32'h1234,0, 1, 0, 5'd0, 32'h1234,     16'd0);
        vecs[3]  = mk(0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  1, 0, 1, 5'd1, 32'h11,       16'd1);
        vecs[4]  = mk(0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 1, 1, 5'd2, 32'h22,       16'd2);
        vecs[5]  = mk(0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  1, 0, 1, 5'd1, 32'h11,       16'd3);
        vecs[6]  = mk(0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 1, 1, 5'd2, 32'h22,       16'd4);
        vecs[7]  = mk(1, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 0, 0, 5'd2, 32'h22,       16'd5);
        vecs[8]  = mk(1, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 0, 0, 5'd2, 32'h22,       16'd6);
        vecs[9]  = mk(1, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 0, 0, 5'd2, 32'h22,       16'd7);
        vecs[10] = mk(0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  1, 0, 1, 5'd1, 32'h11,       16'd8);
        vecs[11] = mk(1, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 0, 0, 5'd1, 32'h11,       16'd9);
        vecs[12] = mk(0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,  0, 1, 1, 5'd2, 32'h22,       16'd10);
        vecs[13] = mk(0, 1, 5'd0, 32'hAAAA,      0, 5'd0, 32'h0,   1, 0, 0, 5'd0, 32'hAAAA,     16'd10);
        vecs[14] = mk(0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,   0, 0, 0, 5'd0, 32'hAAAA,     16'd10);
        vecs[15] = mk(1, 1, 5'd3, 32'h33,        0, 5'd0, 32'h0,   0, 0, 0, 5'd0, 32'hAAAA,     16'd10);
        vecs[16] = mk(0, 1, 5'd3, 32'h33,        0, 5'd0, 32'h0,   1, 0, 1, 5'd3, 32'h33,       16'd10);
        vecs[17] = mk(0, 1, 5'd9, 32'h91,        1, 5'd9, 32'h92,  0, 1, 1, 5'd9, 32'h92,       16'd11);
        vecs[18] = mk(0, 1, 5'd9, 32'h91,        0, 5'd0, 32'h0,   1, 0, 1, 5'd9, 32'h91,       16'd11);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset req0_ready", 64'(bus.req0_ready_o), 64'd0);
        check("reset req1_ready", 64'(bus.req1_ready_o), 64'd0);
        check_outputs("reset", 1'b0, 5'd0, 32'd0, 16'd0);
        check("reset pri_state", 64'(pri_state_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) apply(i, vecs[i]);

        // Reset in the cycle after a grant cancels the in-flight write.
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("pre-reset Reg_Write", 64'(bus.Reg_Write_o), 64'd1);
        drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        reset = 1'b1;
        #1;
        check_outputs("async reset", 1'b0, 5'd0, 32'd0, 16'd0);
        check("in reset req0_ready", 64'(bus.req0_ready_o), 64'd0);
        check("in reset req1_ready", 64'(bus.req1_ready_o), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-reset req0_ready", 64'(bus.req0_ready_o), 64'd1);
        check("post-reset req1_ready", 64'(bus.req1_ready_o), 64'd0);
        @(posedge clk);
        #1;
        check_outputs("post-reset", 1'b1, 5'd1, 32'h11, 16'd1);

        // Saturation of the contention counter.
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        @(negedge clk);
        reset = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        check("contention 0xFFFE", 64'(contention_o), 64'hFFFE);
        @(posedge clk);
        #1;
        check("contention 0xFFFF", 64'(contention_o), 64'hFFFF);
        repeat (6) @(posedge clk);
        #1;
        check("contention saturated", 64'(contention_o), 64'hFFFF);
        check("held Reg_Write", 64'(bus.Reg_Write_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
